// File: rtl/execute_writeback_unit_if.sv
// execute_writeback_unit_if: instruction, register-writeback and data-memory handshake bundle
interface execute_writeback_unit_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        opcode;
  logic [REG_AW-1:0] destReg;
  logic [DATA_W-1:0] srcVal1;
  logic [DATA_W-1:0] srcVal2;
  logic [MEM_AW-1:0] memAddr;
  logic              used1;
  logic              used2;
  logic [REG_AW-1:0] destRegStore;
  logic [DATA_W-1:0] destVal;
  logic              storeNow;
  logic              storeDone;
  logic [MEM_AW-1:0] memAddrLoadStore;
  logic [DATA_W-1:0] memValueStore;
  logic [DATA_W-1:0] memValueLoad;
  logic              valueReady;
  logic              readReq;
  logic              writeReq;
  logic [15:0]       ProcessorStatusWord;
  logic              powerdown;
  modport master (
    output in_valid, opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2,
           storeDone, memValueLoad, valueReady, powerdown,
    input  in_ready, destRegStore, destVal, storeNow, memAddrLoadStore, memValueStore,
           readReq, writeReq, ProcessorStatusWord
  );
  modport slave (
    input  in_valid, opcode, destReg, srcVal1, srcVal2, memAddr, used1, used2,
           storeDone, memValueLoad, valueReady, powerdown,
    output in_ready, destRegStore, destVal, storeNow, memAddrLoadStore, memValueStore,
           readReq, writeReq, ProcessorStatusWord
  );
endinterface

// File: rtl/execute_writeback_unit.sv
// execute_writeback_unit: executes one decoded instruction, writes back via storeNow/storeDone, accesses memory via readReq/writeReq
module execute_writeback_unit #(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 4,
  parameter int MEM_AW     = 8,
  parameter int MUL_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  execute_writeback_unit_if.slave bus
);
  localparam int SW = $clog2(DATA_W);
  localparam int CW = $clog2(MUL_CYCLES);
  typedef enum logic [2:0] {IDLE, WB, MUL, MEM_RD, MEM_WR, PDOWN} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] res_q, res_d, a_q, a_d, b_q, b_d, last_q, last_d, sdata_q, sdata_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [3:0]        flags_q, flags_d;
  logic              ill_q, ill_d;
  logic              acc, wb_op, flag_op, mem_op, mul_done;
  logic [DATA_W-1:0] a, b, alu_res;
  logic              alu_c, alu_v;
  logic [DATA_W:0]   sum, dif;
  logic [2*DATA_W-1:0] prod;
  assign acc      = bus.in_valid && bus.in_ready;
  assign a        = bus.used1 ? last_q : bus.srcVal1;
  assign b        = bus.used2 ? last_q : bus.srcVal2;
  assign wb_op    = bus.opcode inside {4'd1, 4'd2, [4'd4:4'd9]};
  assign flag_op  = wb_op || bus.opcode == 4'd10;
  assign mem_op   = bus.opcode == 4'd11 || bus.opcode == 4'd12;
  assign mul_done = state_q == MUL && cnt_q == '0;
  assign prod     = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
  // Single-cycle ALU on the bypassed operands; SUB and CMP share the borrow-producing subtractor
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    dif     = {1'b0, a} - {1'b0, b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.opcode)
      4'd1: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = a[DATA_W-1] == b[DATA_W-1] && alu_res[DATA_W-1] != a[DATA_W-1];
      end
      4'd2, 4'd10: begin
        alu_res = dif[DATA_W-1:0];
        alu_c   = dif[DATA_W];
        alu_v   = a[DATA_W-1] != b[DATA_W-1] && alu_res[DATA_W-1] != a[DATA_W-1];
      end
      4'd4: alu_res = a & b;
      4'd5: alu_res = a | b;
      4'd6: alu_res = a ^ b;
      4'd7: alu_res = ~a;
      4'd8: alu_res = a << b[SW-1:0];
      4'd9: alu_res = a >> b[SW-1:0];
      default: alu_res = '0;
    endcase
  end
  // Next-state logic; powerdown is only honoured from IDLE so in-flight work always completes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.powerdown) state_d = PDOWN;
        else if (acc && wb_op) state_d = WB;
        else if (acc && bus.opcode == 4'd3) begin
          state_d = MUL;
          cnt_d   = CW'(MUL_CYCLES - 1);
        end
        else if (acc && bus.opcode == 4'd11) state_d = MEM_RD;
        else if (acc && bus.opcode == 4'd12) state_d = MEM_WR;
      end
      WB:      state_d = bus.storeDone ? IDLE : WB;
      MUL: begin
        state_d = cnt_q == '0 ? WB : MUL;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
      end
      MEM_RD:  state_d = bus.valueReady ? WB : MEM_RD;
      MEM_WR:  state_d = bus.valueReady ? IDLE : MEM_WR;
      PDOWN:   state_d = bus.powerdown ? PDOWN : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Datapath next values: capture at accept, register multiply/load results, remember last writeback
  always_comb begin
    dest_d  = dest_q;
    res_d   = res_q;
    a_d     = a_q;
    b_d     = b_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    flags_d = flags_q;
    ill_d   = ill_q;
    last_d  = last_q;
    if (acc) begin
      ill_d  = bus.opcode > 4'd12;
      dest_d = bus.destReg;
      a_d    = a;
      b_d    = b;
      if (wb_op) res_d = alu_res;
      if (flag_op) flags_d = {alu_v, alu_c, alu_res[DATA_W-1], alu_res == '0};
      if (mem_op) begin
        addr_d  = bus.memAddr;
        sdata_d = b;
      end
    end
    if (mul_done) begin
      res_d   = prod[DATA_W-1:0];
      flags_d = {1'b0, |prod[2*DATA_W-1:DATA_W], prod[DATA_W-1], prod[DATA_W-1:0] == '0};
    end
    if (state_q == MEM_RD && bus.valueReady) res_d = bus.memValueLoad;
    if (state_q == WB && bus.storeDone) last_d = res_q;
  end
  // State register with asynchronous abort of any in-flight operation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dest_q  <= '0;
      res_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      flags_q <= '0;
      ill_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      dest_q  <= dest_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      flags_q <= flags_d;
      ill_q   <= ill_d;
      last_q  <= last_d;
    end
  end
  // Outputs decoded from state; in_ready is gated by rst so every output is 0 while reset is held
  always_comb begin
    bus.in_ready            = rst && state_q == IDLE && !bus.powerdown;
    bus.storeNow            = state_q == WB;
    bus.readReq             = state_q == MEM_RD;
    bus.writeReq            = state_q == MEM_WR;
    bus.destRegStore        = dest_q;
    bus.destVal             = res_q;
    bus.memAddrLoadStore    = addr_q;
    bus.memValueStore       = sdata_q;
    bus.ProcessorStatusWord = {9'b0, state_q == PDOWN, state_q inside {WB, MUL, MEM_RD, MEM_WR}, ill_q, flags_q};
  end
endmodule

// File: tb/tb_execute_writeback_unit.sv
// tb_execute_writeback_unit: randomized scoreboard bench for execute_writeback_unit
module tb_execute_writeback_unit;
  localparam int DW = 16;
  localparam int RW = 4;
  localparam int MW = 8;
  localparam int MC = 4;
  typedef struct { logic [RW-1:0] dest; logic [DW-1:0] val; int first; } wb_t;
  typedef struct { logic [MW-1:0] addr; logic [DW-1:0] data; logic wr; } mem_t;
  logic clk = 0;
  logic rst = 0;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  bit   fresh = 1;
  wb_t  wb_q[$];
  mem_t mem_q[$];
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] m_last;
  logic [3:0]    m_flags;
  logic          m_ill;
  execute_writeback_unit_if #(.DATA_W(DW), .REG_AW(RW), .MEM_AW(MW)) bus ();
  execute_writeback_unit #(.DATA_W(DW), .REG_AW(RW), .MEM_AW(MW), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] outs();
    return {bus.in_ready, bus.storeNow, bus.readReq, bus.writeReq, bus.destRegStore, bus.destVal,
            bus.memAddrLoadStore, bus.memValueStore, bus.ProcessorStatusWord};
  endfunction
  // Register file side: storeDone toggles randomly, also outside writeback
  initial begin
    bus.storeDone = 0;
    forever begin
      @(posedge clk); #1;
      bus.storeDone = $urandom_range(0, 2) == 0;
    end
  end
  // Memory side: answers requests after a random delay from its own array
  initial begin
    bus.valueReady = 0;
    bus.memValueLoad = 0;
    forever begin
      @(posedge clk); #1;
      if ((bus.readReq || bus.writeReq) && !bus.valueReady && $urandom_range(0, 2) == 0) begin
        bus.valueReady = 1;
        if (bus.readReq) bus.memValueLoad = ram[bus.memAddrLoadStore];
        else ram[bus.memAddrLoadStore] = bus.memValueStore;
      end else bus.valueReady = 0;
    end
  end
  // Monitor: pops expectations whenever the DUT presents a writeback or memory request
  always @(negedge clk) if (rst) begin
    check("req_excl", 64'(bus.readReq & bus.writeReq), 64'(0));
    check("store_vs_req", 64'(bus.storeNow & (bus.readReq | bus.writeReq)), 64'(0));
    check("busy_ready", 64'(bus.ProcessorStatusWord[5] & bus.in_ready), 64'(0));
    if (bus.storeNow) begin
      if (wb_q.size() == 0) check("unexpected_wb", 64'(bus.storeNow), 64'(0));
      else begin
        if (fresh && wb_q[0].first >= 0) check("wb_latency", 64'(cyc), 64'(wb_q[0].first));
        fresh = 0;
        check("wb_dest", 64'(bus.destRegStore), 64'(wb_q[0].dest));
        check("wb_val", 64'(bus.destVal), 64'(wb_q[0].val));
        if (bus.storeDone) begin
          void'(wb_q.pop_front());
          fresh = 1;
        end
      end
    end
    if (bus.readReq || bus.writeReq) begin
      if (mem_q.size() == 0) check("unexpected_mem", 64'(bus.readReq | bus.writeReq), 64'(0));
      else begin
        check("mem_kind", 64'(bus.writeReq), 64'(mem_q[0].wr));
        check("mem_addr", 64'(bus.memAddrLoadStore), 64'(mem_q[0].addr));
        if (mem_q[0].wr) check("mem_data", 64'(bus.memValueStore), 64'(mem_q[0].data));
        if (bus.valueReady) void'(mem_q.pop_front());
      end
    end
  end
  task automatic wait_idle();
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", 64'(bus.in_ready), 64'(1));
  endtask
  task automatic issue(input logic [3:0] op, input logic [RW-1:0] d, input logic [DW-1:0] s1, input logic [DW-1:0] s2,
                       input logic [MW-1:0] ad, input logic u1, input logic u2);
    logic [DW-1:0] a, b, r;
    logic [31:0] full;
    logic c, v, wb;
    int sa, sb, lat;
    wait_idle();
    a = u1 ? m_last : s1;
    b = u2 ? m_last : s2;
    sa = $signed(a);
    sb = $signed(b);
    r = '0; c = 0; v = 0;
    case (op)
      4'd1: begin full = 32'(a) + 32'(b); r = full[DW-1:0]; c = full[DW]; v = sa + sb > 32767 || sa + sb < -32768; end
      4'd2, 4'd10: begin r = a - b; c = a < b; v = sa - sb > 32767 || sa - sb < -32768; end
      4'd3: begin full = 32'(a) * 32'(b); r = full[DW-1:0]; c = full[31:DW] != 0; end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: r = ~a;
      4'd8: r = a << b[3:0];
      4'd9: r = a >> b[3:0];
      4'd11: r = ref_mem[ad];
      4'd12: ref_mem[ad] = b;
      default: r = '0;
    endcase
    wb = op inside {[4'd1:4'd9], 4'd11};
    lat = op == 4'd3 ? MC : op == 4'd11 ? -1 : 0;
    if (op inside {[4'd1:4'd10]}) m_flags = {v, c, r[DW-1], r == '0};
    m_ill = op > 4'd12;
    if (op == 4'd11 || op == 4'd12) mem_q.push_back('{ad, b, op == 4'd12});
    bus.opcode = op; bus.destReg = d; bus.srcVal1 = s1; bus.srcVal2 = s2;
    bus.memAddr = ad; bus.used1 = u1; bus.used2 = u2; bus.in_valid = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    if (wb) begin
      wb_q.push_back('{d, r, lat < 0 ? -1 : cyc + lat});
      m_last = r;
    end
    wait_idle();
    check("psw", 64'(bus.ProcessorStatusWord), 64'({11'b0, m_ill, m_flags}));
  endtask
  initial begin
    bus.in_valid = 0; bus.opcode = 0; bus.destReg = 0; bus.srcVal1 = 0; bus.srcVal2 = 0;
    bus.memAddr = 0; bus.used1 = 0; bus.used2 = 0; bus.powerdown = 0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'($urandom);
      ref_mem[i] = ram[i];
    end
    m_last = 0; m_flags = 0; m_ill = 0;
    #12;
    check("reset_outs", outs(), 64'(0));
    @(posedge clk); #1;
    rst = 1;
    issue(4'd1, 4'd12, 16'd24, 16'd30, 8'd0, 0, 0);
    issue(4'd2, 4'd1, 16'd25, 16'd9, 8'd0, 0, 0);
    issue(4'd2, 4'd1, 16'd9, 16'd25, 8'd0, 0, 0);
    issue(4'd10, 4'd0, 16'd5, 16'd5, 8'd0, 0, 0);
    issue(4'd3, 4'd3, 16'd300, 16'd300, 8'd0, 0, 0);
    issue(4'd12, 4'd0, 16'd0, 16'd45, 8'd180, 0, 0);
    issue(4'd11, 4'd5, 16'd0, 16'd0, 8'd180, 0, 0);
    issue(4'd1, 4'd2, 16'd15, 16'd14, 8'd0, 0, 0);
    issue(4'd1, 4'd3, 16'hDEAD, 16'hDEAD, 8'd0, 1, 1);
    issue(4'd14, 4'd7, 16'd1, 16'd2, 8'd3, 0, 0);
    issue(4'd0, 4'd7, 16'd1, 16'd2, 8'd3, 0, 0);
    bus.powerdown = 1;
    #1;
    check("pd_ready", 64'(bus.in_ready), 64'(0));
    @(posedge clk); #1;
    check("pd_psw", 64'(bus.ProcessorStatusWord), 64'({9'b0, 1'b1, 1'b0, m_ill, m_flags}));
    bus.opcode = 4'd1; bus.in_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    check("pd_hold", 64'({bus.in_ready, bus.ProcessorStatusWord[6], bus.readReq, bus.writeReq}), 64'(4'b0100));
    bus.in_valid = 0; bus.powerdown = 0;
    @(posedge clk); #1;
    check("pd_exit", 64'({bus.in_ready, bus.ProcessorStatusWord[6]}), 64'(2'b10));
    for (int i = 0; i < 300; i++)
      issue(4'($urandom_range(0, 15)), 4'($urandom),
            $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 20)) : 16'($urandom),
            $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 20)) : 16'($urandom),
            8'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    wait_idle();
    bus.opcode = 4'd3; bus.destReg = 4'd9; bus.srcVal1 = 16'd7; bus.srcVal2 = 16'd9;
    bus.used1 = 0; bus.used2 = 0; bus.in_valid = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    check("mul_busy", 64'({bus.in_ready, bus.ProcessorStatusWord[5]}), 64'(2'b01));
    @(posedge clk); #3;
    rst = 0;
    #1;
    check("rst_async", outs(), 64'(0));
    wb_q.delete(); mem_q.delete(); fresh = 1;
    m_last = 0; m_flags = 0; m_ill = 0;
    @(posedge clk); #1;
    rst = 1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst", 64'({bus.in_ready, bus.ProcessorStatusWord}), 64'({1'b1, 16'b0}));
    issue(4'd1, 4'd4, 16'd0, 16'd7, 8'd0, 1, 0);
    issue(4'd3, 4'd6, 16'hFFFF, 16'd2, 8'd0, 0, 1);
    wait_idle();
    check("wb_drain", 64'(wb_q.size()), 64'(0));
    check("mem_drain", 64'(mem_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
